// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters
// with round-robin arbitration, registered operands, multi-cycle multiply hold
// and a per-requester response handshake.
module alu_arbiter #(
   parameter int unsigned MUL_LAT = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [3:0]  req0_ctrl_i,
   input  logic [31:0] req0_data1_i,
   input  logic [31:0] req0_data2_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [3:0]  req1_ctrl_i,
   input  logic [31:0] req1_data1_i,
   input  logic [31:0] req1_data2_i,
   output logic        rsp0_valid_o,
   input  logic        rsp0_ready_i,
   output logic [31:0] rsp0_data_o,
   output logic        rsp1_valid_o,
   input  logic        rsp1_ready_i,
   output logic [31:0] rsp1_data_o,
   output logic [3:0]  alu_ctrl_o,
   output logic [31:0] alu_data1_o,
   output logic [31:0] alu_data2_o,
   input  logic [31:0] alu_data_i
);

   localparam int unsigned DW      = 32;
   localparam int unsigned CW      = 4;
   localparam logic [CW-1:0] CTRL_MUL = 4'b1010;
   // Multiply stays in EXEC for MUL_LAT cycles; everything else for one.
   localparam logic [3:0]    MUL_CNT  = 4'(MUL_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   op_ctrl;
   logic [DW-1:0]   op_a;
   logic [DW-1:0]   op_b;
   logic            owner;
   logic            last_grant;
   logic [3:0]      cnt;
   logic [DW-1:0]   result;

   logic            grant_c;
   logic            accept_c;
   logic            rsp_take_c;
   logic [CW-1:0]   sel_ctrl_c;
   logic [DW-1:0]   sel_a_c;
   logic [DW-1:0]   sel_b_c;

   // Round-robin grant: a tie goes to the requester not served last.
   always_comb begin
      grant_c = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         grant_c = ~last_grant;
      end else if (req1_valid_i) begin
         grant_c = 1'b1;
      end
   end

   assign accept_c   = (state == IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;
   assign rsp_take_c = (state == RESP) && (owner ? rsp1_ready_i : rsp0_ready_i);

   assign sel_ctrl_c = grant_c ? req1_ctrl_i  : req0_ctrl_i;
   assign sel_a_c    = grant_c ? req1_data1_i : req0_data1_i;
   assign sel_b_c    = grant_c ? req1_data2_i : req0_data2_i;

   // Ready is a direct decode of the grant; reset forces both low immediately.
   assign req0_ready_o = (state == IDLE) && !rst_i && !grant_c && req0_valid_i;
   assign req1_ready_o = (state == IDLE) && !rst_i &&  grant_c && req1_valid_i;

   assign rsp0_valid_o = (state == RESP) && !owner;
   assign rsp1_valid_o = (state == RESP) &&  owner;
   assign rsp0_data_o  = owner ? '0 : result;
   assign rsp1_data_o  = owner ? result : '0;

   assign alu_ctrl_o  = op_ctrl;
   assign alu_data1_o = op_a;
   assign alu_data2_o = op_b;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c)    state_nxt = EXEC;
         EXEC:    if (cnt == '0)   state_nxt = RESP;
         RESP:    if (rsp_take_c)  state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Operand/owner latch at accept, settle counter, result capture, grant history.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_ctrl    <= '0;
         op_a       <= '0;
         op_b       <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         result     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  op_ctrl <= sel_ctrl_c;
                  op_a    <= sel_a_c;
                  op_b    <= sel_b_c;
                  owner   <= grant_c;
                  cnt     <= (sel_ctrl_c == CTRL_MUL) ? MUL_CNT : 4'd0;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  result <= alu_data_i;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_take_c) begin
                  last_grant <= owner;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
   logic        req0_ready_o, req1_ready_o;
   logic [3:0]  req0_ctrl_i = '0, req1_ctrl_i = '0;
   logic [31:0] req0_data1_i = '0, req0_data2_i = '0;
   logic [31:0] req1_data1_i = '0, req1_data2_i = '0;
   logic        rsp0_valid_o, rsp1_valid_o;
   logic        rsp0_ready_i = 1'b0, rsp1_ready_i = 1'b0;
   logic [31:0] rsp0_data_o, rsp1_data_o;
   logic [3:0]  alu_ctrl_o;
   logic [31:0] alu_data1_o, alu_data2_o;
   logic [31:0] alu_data_i;

   int n_checks = 0;
   int n_pass   = 0;

   alu_arbiter #(.MUL_LAT(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_ctrl_i(req0_ctrl_i),
      .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_ctrl_i(req1_ctrl_i),
      .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_data_o(rsp0_data_o),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_data_o(rsp1_data_o),
      .alu_ctrl_o(alu_ctrl_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
      .alu_data_i(alu_data_i)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural ALU: unsupported codes yield 0.
   always_comb begin
      alu_data_i = '0;
      case (alu_ctrl_o)
         4'b0010: alu_data_i = alu_data1_o + alu_data2_o;
         4'b0110: alu_data_i = alu_data1_o - alu_data2_o;
         4'b0000: alu_data_i = alu_data1_o & alu_data2_o;
         4'b0001: alu_data_i = alu_data1_o | alu_data2_o;
         4'b1010: alu_data_i = 32'(alu_data1_o * alu_data2_o);
         default: alu_data_i = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_i = 1'b1;
      tick();
      tick();
      #2 rst_i = 1'b0;
      tick();
   endtask

   task automatic drive0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      req0_valid_i = v; req0_ctrl_i = c; req0_data1_i = a; req0_data2_i = b;
   endtask

   task automatic drive1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      req1_valid_i = v; req1_ctrl_i = c; req1_data1_i = a; req1_data2_i = b;
   endtask

   initial begin
      logic [31:0] exp_data;
      logic        own;

      // Reset state, with both requesters already asserting valid.
      drive0(1'b1, 4'b0010, 32'd1, 32'd1);
      drive1(1'b1, 4'b0010, 32'd2, 32'd2);
      #1 rst_i = 1'b1;
      tick();
      #1;
      check("rst_ready0", 32'(req0_ready_o), 32'd0);
      check("rst_ready1", 32'(req1_ready_o), 32'd0);
      check("rst_rsp0_valid", 32'(rsp0_valid_o), 32'd0);
      check("rst_rsp1_valid", 32'(rsp1_valid_o), 32'd0);
      check("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
      check("rst_alu_a", alu_data1_o, 32'd0);
      check("rst_alu_b", alu_data2_o, 32'd0);
      check("rst_rsp0_data", rsp0_data_o, 32'd0);
      check("rst_rsp1_data", rsp1_data_o, 32'd0);
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      drive1(1'b0, 4'b0, 32'd0, 32'd0);
      #2 rst_i = 1'b0;
      tick();

      // Single add 5+7.
      drive0(1'b1, 4'b0010, 32'd5, 32'd7);
      rsp0_ready_i = 1'b1;
      #1;
      check("add_ready0", 32'(req0_ready_o), 32'd1);
      check("add_ready1", 32'(req1_ready_o), 32'd0);
      tick();
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      #1;
      check("add_exec_ready0", 32'(req0_ready_o), 32'd0);
      check("add_exec_valid", 32'(rsp0_valid_o), 32'd0);
      check("add_alu_ctrl", 32'(alu_ctrl_o), 32'h2);
      check("add_alu_a", alu_data1_o, 32'd5);
      check("add_alu_b", alu_data2_o, 32'd7);
      tick();
      check("add_rsp0_valid", 32'(rsp0_valid_o), 32'd1);
      check("add_rsp0_data", rsp0_data_o, 32'd12);
      check("add_rsp1_valid", 32'(rsp1_valid_o), 32'd0);
      check("add_rsp1_data", rsp1_data_o, 32'd0);
      tick();
      check("add_done_valid", 32'(rsp0_valid_o), 32'd0);

      // Simultaneous requests: strict alternation starting with req0.
      do_reset();
      drive0(1'b1, 4'b0110, 32'd3, 32'd5);
      drive1(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
      rsp0_ready_i = 1'b1;
      rsp1_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         own      = k[0];
         exp_data = own ? 32'h0000_00FF : 32'hFFFF_FFFE;
         #1;
         check($sformatf("rr%0d_ready0", k), 32'(req0_ready_o), 32'(!own));
         check($sformatf("rr%0d_ready1", k), 32'(req1_ready_o), 32'(own));
         tick();
         check($sformatf("rr%0d_exec_both", k), 32'(req0_ready_o | req1_ready_o), 32'd0);
         tick();
         check($sformatf("rr%0d_valid0", k), 32'(rsp0_valid_o), 32'(!own));
         check($sformatf("rr%0d_valid1", k), 32'(rsp1_valid_o), 32'(own));
         check($sformatf("rr%0d_data", k), own ? rsp1_data_o : rsp0_data_o, exp_data);
         check($sformatf("rr%0d_resp_both", k), 32'(req0_ready_o | req1_ready_o), 32'd0);
         tick();
      end
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      drive1(1'b0, 4'b0, 32'd0, 32'd0);
      tick();

      // Multiply 6*7 on req1 with MUL_LAT=3.
      drive1(1'b1, 4'b1010, 32'd6, 32'd7);
      #1;
      check("mul_ready1", 32'(req1_ready_o), 32'd1);
      tick();
      drive1(1'b0, 4'b0, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("mul_exec%0d_ctrl", i), 32'(alu_ctrl_o), 32'hA);
         check($sformatf("mul_exec%0d_valid", i), 32'(rsp1_valid_o), 32'd0);
         tick();
      end
      check("mul_rsp1_valid", 32'(rsp1_valid_o), 32'd1);
      check("mul_rsp1_data", rsp1_data_o, 32'd42);
      tick();

      // Response backpressure: last_grant is 1, so req0 wins the tie.
      rsp0_ready_i = 1'b0;
      drive0(1'b1, 4'b0000, 32'h0000_FFFF, 32'h0000_0F0F);
      drive1(1'b1, 4'b0010, 32'd1, 32'd2);
      #1;
      check("bp_ready0", 32'(req0_ready_o), 32'd1);
      check("bp_ready1", 32'(req1_ready_o), 32'd0);
      tick();
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      #1;
      check("bp_exec_ready1", 32'(req1_ready_o), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d_valid0", i), 32'(rsp0_valid_o), 32'd1);
         check($sformatf("bp%0d_data0", i), rsp0_data_o, 32'h0000_0F0F);
         check($sformatf("bp%0d_ready1", i), 32'(req1_ready_o), 32'd0);
         tick();
      end
      rsp0_ready_i = 1'b1;
      tick();
      check("bp_after_valid0", 32'(rsp0_valid_o), 32'd0);
      check("bp_after_ready1", 32'(req1_ready_o), 32'd1);
      tick();
      drive1(1'b0, 4'b0, 32'd0, 32'd0);
      tick();
      check("bp_req1_valid", 32'(rsp1_valid_o), 32'd1);
      check("bp_req1_data", rsp1_data_o, 32'd3);
      tick();

      // Unsupported control code.
      drive0(1'b1, 4'b1111, 32'd9, 32'd9);
      #1;
      check("unsup_ready0", 32'(req0_ready_o), 32'd1);
      tick();
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      tick();
      check("unsup_valid", 32'(rsp0_valid_o), 32'd1);
      check("unsup_data", rsp0_data_o, 32'd0);
      tick();

      // Reset in the middle of a multiply.
      drive0(1'b1, 4'b1010, 32'd6, 32'd7);
      tick();
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      tick();
      #2 rst_i = 1'b1;
      drive0(1'b1, 4'b0010, 32'd1, 32'd1);
      drive1(1'b1, 4'b0010, 32'd1, 32'd1);
      #1;
      check("mrst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
      check("mrst_alu_a", alu_data1_o, 32'd0);
      check("mrst_ready0", 32'(req0_ready_o), 32'd0);
      check("mrst_ready1", 32'(req1_ready_o), 32'd0);
      check("mrst_valids", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
      check("mrst_rsp0_data", rsp0_data_o, 32'd0);
      drive0(1'b0, 4'b0, 32'd0, 32'd0);
      drive1(1'b0, 4'b0, 32'd0, 32'd0);
      tick();
      #2 rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("mrst_norsp%0d", i), 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
      end
      drive0(1'b1, 4'b0010, 32'd1, 32'd1);
      drive1(1'b1, 4'b0010, 32'd2, 32'd2);
      #1;
      check("mrst_tie_ready0", 32'(req0_ready_o), 32'd1);
      check("mrst_tie_ready1", 32'(req1_ready_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters (e.g. the EX stage and a multi-cycle helper unit) using valid/ready handshakes and round-robin arbitration. Operands are registered before they reach the ALU, and multiplies are held for a parameterised number of settle cycles. The result is captured and returned to the owning requester through a response handshake. The block sits between the requesters and the ALU, and drives the ALU's control and operand inputs directly.

## Interface
- MUL_LAT, 3: cycles the ALU inputs are held for ctrl 4'b1010 (multiply) before the result is captured; legal range 1..15.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- reqN_valid_i  input  1  (N=0,1) requester N presents an operation.
- reqN_ready_o  output  1  block accepts requester N's operation this cycle.
- reqN_ctrl_i  input  4  ALU control code: 0010 add, 0110 sub, 0000 and, 0001 or, 1010 mul.
- reqN_data1_i, reqN_data2_i  input  32  operands.
- rspN_valid_o  output  1  result for requester N is available.
- rspN_ready_i  input  1  requester N takes the result.
- rspN_data_o  output  32  result.
- alu_ctrl_o  output  4  to ALU control input.
- alu_data1_o, alu_data2_o  output  32  to ALU operand inputs.
- alu_data_i  input  32  ALU result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Registers:
  - op_ctrl, op_a, op_b.
  - owner (1 bit).
  - last_grant (1 bit).
  - cnt (4 bits).
  - result (32 bits).
- alu_ctrl_o/alu_data1_o/alu_data2_o = op_ctrl/op_a/op_b in every state. The ALU never sees requester inputs directly.
- IDLE:
  - grant = requester with valid. If both are valid, grant = !last_grant.
  - reqN_ready_o = (state==IDLE) && grant==N && reqN_valid_i. This is combinational, and at most one ready is high.
  - On accept: latch ctrl/operands and owner=grant. Load cnt = MUL_LAT-1 if ctrl==1010, else 0. Go to EXEC.
- EXEC:
  - If cnt==0: result <= alu_data_i, go to RESP.
  - Else cnt <= cnt-1.
- RESP:
  - rsp{owner}_valid_o=1 and rsp{owner}_data_o=result. The other response port has valid=0.
  - When rsp{owner}_ready_i=1: go to IDLE and set last_grant <= owner.
- rspN_data_o outputs result when owner==N, and 0 otherwise.
- Any ctrl code is accepted with latency 1. Unsupported codes return whatever the ALU produces (0).
- Arithmetic is 32-bit modulo. Sub wraps, and mul keeps the low 32 bits (the block does no arithmetic itself).
- Requesters hold valid and operands stable until ready. The block must not depend on this, because it latches operands at accept.
- Reset mid-operation: the transaction is dropped and no response is issued. The requester re-issues.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - cnt=0, owner=0, op_ctrl=0, op_a=0, op_b=0, result=0.
  - All ready/valid outputs 0.
  - alu_* outputs 0.
  - rsp*_data_o 0.
- Accept at edge E0 (valid&&ready). The result is captured at edge E0+L, where L=MUL_LAT for mul and L=1 otherwise.
- rspN_valid_o is high from after E0+L until the handshake edge Er; Er ≥ E0+L+1.
- If rspN_ready_i is already high, the handshake completes on the first RESP cycle. The minimum occupancy is L+1 cycles per operation.
- The earliest next accept is the edge after Er. The ready outputs are low throughout EXEC and RESP.
- Back-to-back contention alternates strictly between 0 and 1. Neither requester waits more than one operation.

## Test plan
- Single add after reset:
  - Stimulus: req0 add 5+7, rsp0_ready_i=1.
  - Response: req0_ready_o high in the accept cycle. rsp0_valid_o high 1 cycle later with data 12. rsp1_valid_o stays 0.
- Simultaneous requests:
  - Stimulus: req0 and req1 both valid continuously, req0 sub 3-5, req1 or 0xF0|0x0F, responses always ready.
  - Response: req0 served first (0xFFFFFFFE), then req1 (0xFF), then req0 again.
  - Check: grants strictly alternate, and ready is never high on both ports.
- Multiply latency (MUL_LAT=3):
  - Stimulus: req1 mul 6*7.
  - Response: rsp1_valid_o first high exactly 3 cycles after the accept edge, data 42. alu_ctrl_o=1010 is held during all 3 EXEC cycles.
- Response backpressure:
  - Stimulus: req0 and 0xFFFF&0x0F0F, rsp0_ready_i low for 5 cycles, with req1 valid meanwhile.
  - Response: rsp0_valid_o and data 0x0F0F held stable for the 5 cycles, and req1_ready_o stays 0. After the handshake, req1 is accepted on the next cycle.
- Unsupported code:
  - Stimulus: req0 ctrl 1111 with operands 9,9.
  - Response: accepted, and the response data is 0 after 1 cycle.
- Reset mid-operation:
  - Stimulus: assert rst_i during EXEC of a multiply, asynchronously between edges.
  - Response: all outputs drop to 0 immediately, no response is issued, and after release req0 wins a tie.
